// File: rtl/wb_pkg.sv
// Shared constants for the write-back source selector: source-select codes and FSM states.
package wb_pkg;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_SW  = 2'd1;
  localparam logic [1:0] SEL_IMM = 2'd2;
  localparam logic [1:0] SEL_MEM = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SW  = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Rising-edge detector for a level input, with an optional 2-flop synchroniser
// in front of it when WB_SW_SYNC_EN is defined.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic level_s;
  logic prev_r;

`ifdef WB_SW_SYNC_EN
  logic [1:0] sync_r;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], din};
    end
  end

  assign level_s = sync_r[1];
`else
  assign level_s = din;
`endif

  // History of the previous sample, updated every cycle regardless of FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  assign rise = level_s & ~prev_r;

endmodule

// File: rtl/wb_select.sv
// Write-back source selector: picks ALU, switch, immediate or memory data and
// emits a one-cycle wb_valid on completion. WB_SW_SYNC_EN adds switch synchronisers.
module wb_select
  import wb_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [1:0]        req_sel,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_enter,
  input  logic [IMM_W-1:0]  imm_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              req_ready,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  state_t              state_r;
  state_t              next_state_s;
  logic                load_s;
  logic [DATA_W-1:0]   load_val_s;
  logic [DATA_W-1:0]   imm_ext_s;
  logic [DATA_W-1:0]   sw_use_s;
  logic                enter_rise_s;
  logic                wb_valid_r;
  logic [DATA_W-1:0]   wb_data_r;

`ifdef WB_SW_SYNC_EN
  logic [DATA_W-1:0] sw_meta_r;
  logic [DATA_W-1:0] sw_sync_r;

  // Switch data follows the same two-flop path as sw_enter so both line up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_r <= '0;
      sw_sync_r <= '0;
    end else begin
      sw_meta_r <= sw_data;
      sw_sync_r <= sw_meta_r;
    end
  end

  assign sw_use_s = sw_sync_r;
`else
  assign sw_use_s = sw_data;
`endif

  edge_sync u_enter_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sw_enter),
    .rise  (enter_rise_s)
  );

  // Zero-extend the immediate field to the write-back width
  always_comb begin
    imm_ext_s = '0;
    imm_ext_s[IMM_W-1:0] = imm_data;
  end

  // Next-state and write-back load selection
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    load_val_s   = alu_data;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          case (req_sel)
            SEL_ALU: begin
              load_s     = 1'b1;
              load_val_s = alu_data;
            end
            SEL_IMM: begin
              load_s     = 1'b1;
              load_val_s = imm_ext_s;
            end
            SEL_SW:  next_state_s = WAIT_SW;
            SEL_MEM: next_state_s = WAIT_MEM;
            default: next_state_s = IDLE;
          endcase
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_SW: begin
        if (enter_rise_s) begin
          load_s       = 1'b1;
          load_val_s   = sw_use_s;
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_SW;
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          load_s       = 1'b1;
          load_val_s   = mem_data;
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_MEM;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State and registered write-back outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wb_valid_r <= 1'b0;
      wb_data_r  <= '0;
    end else begin
      state_r    <= next_state_s;
      wb_valid_r <= load_s;
      if (load_s) begin
        wb_data_r <= load_val_s;
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r == WAIT_SW) || (state_r == WAIT_MEM);
  assign wb_valid  = wb_valid_r;
  assign wb_data   = wb_data_r;

endmodule

// File: tb/tb_wb_select.sv
// Self-checking bench for wb_select: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_wb_select;

  localparam int DW = 10;
  localparam int IW = 4;
`ifdef WB_SW_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_sel = 2'd0;
  logic [DW-1:0] alu_data = '0;
  logic [DW-1:0] sw_data = '0;
  logic          sw_enter = 1'b0;
  logic [IW-1:0] imm_data = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_valid = 1'b0;
  logic          req_ready;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // reference model: 0 idle, 1 waiting for operator, 2 waiting for memory
  int            m_mode = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          h_en [0:3];
  logic [DW-1:0] h_dat [0:3];

  wb_select #(.DATA_W(DW), .IMM_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .alu_data  (alu_data),
    .sw_data   (sw_data),
    .sw_enter  (sw_enter),
    .imm_data  (imm_data),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .req_ready (req_ready),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge as the spec describes it, using the inputs as currently driven
  task automatic model_edge();
    logic          en_now;
    logic          en_prev;
    logic [DW-1:0] dat_now;
    if (!rst_n) begin
      m_mode  = 0;
      m_valid = 1'b0;
      m_data  = '0;
      for (int i = 0; i < 4; i++) begin
        h_en[i]  = 1'b0;
        h_dat[i] = '0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        h_en[i]  = h_en[i-1];
        h_dat[i] = h_dat[i-1];
      end
      h_en[0]  = sw_enter;
      h_dat[0] = sw_data;
      en_now   = h_en[SYNC_D];
      en_prev  = h_en[SYNC_D+1];
      dat_now  = h_dat[SYNC_D];
      m_valid  = 1'b0;
      if (m_mode == 0) begin
        if (req_valid) begin
          if (req_sel == 2'd0) begin
            m_data = alu_data; m_valid = 1'b1;
          end else if (req_sel == 2'd2) begin
            m_data = DW'(imm_data); m_valid = 1'b1;
          end else if (req_sel == 2'd1) begin
            m_mode = 1;
          end else begin
            m_mode = 2;
          end
        end
      end else if (m_mode == 1) begin
        if (en_now && !en_prev) begin
          m_data = dat_now; m_valid = 1'b1; m_mode = 0;
        end
      end else begin
        if (mem_valid) begin
          m_data = mem_data; m_valid = 1'b1; m_mode = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("wb_valid", 32'(wb_valid), 32'(m_valid));
    check("wb_data", 32'(wb_data), 32'(m_data));
    check("req_ready", 32'(req_ready), 32'(m_mode == 0));
    check("busy", 32'(busy), 32'(m_mode != 0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      h_en[i]  = 1'b0;
      h_dat[i] = '0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_ready", 32'(req_ready), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_valid", 32'(wb_valid), 32'd0);

    // ALU
    req_valid = 1'b1; req_sel = 2'd0; alu_data = 10'h2A5;
    step();
    req_valid = 1'b0;
    check("alu_data", 32'(wb_data), 32'h2A5);
    check("alu_valid", 32'(wb_valid), 32'd1);
    check("alu_ready", 32'(req_ready), 32'd1);
    step();

    // IMM zero-extension
    req_valid = 1'b1; req_sel = 2'd2; imm_data = 4'hF;
    step();
    req_valid = 1'b0;
    check("imm_data", 32'(wb_data), 32'h00F);
    step();

    // SW with sw_enter already high
    sw_enter = 1'b1; sw_data = 10'h155;
    step();
    req_valid = 1'b1; req_sel = 2'd1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("sw_held_busy", 32'(busy), 32'd1);
    sw_enter = 1'b0;
    step();
    sw_enter = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!wb_valid && n < 8);
    check("sw_latency", 32'(n), 32'(SYNC_D + 1));
    check("sw_data", 32'(wb_data), 32'h155);
    step();
    check("sw_pulse_one", 32'(wb_valid), 32'd0);

    // MEM, valid on acceptance ignored
    mem_valid = 1'b1; req_valid = 1'b1; req_sel = 2'd3;
    step();
    req_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("mem_busy", 32'(busy), 32'd1);
    mem_valid = 1'b1; mem_data = 10'h3FF;
    step();
    mem_valid = 1'b0;
    check("mem_data", 32'(wb_data), 32'h3FF);
    check("mem_valid", 32'(wb_valid), 32'd1);

    // back-to-back ALU
    req_valid = 1'b1; req_sel = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      alu_data = DW'(i);
      step();
      check("b2b_data", 32'(wb_data), 32'(i));
      check("b2b_valid", 32'(wb_valid), 32'd1);
    end
    req_valid = 1'b0;
    step();

    // reset during WAIT_MEM
    req_valid = 1'b1; req_sel = 2'd3;
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; mem_valid = 1'b1; mem_data = 10'h0AA;
    step();
    mem_valid = 1'b0;
    check("rst_wait_valid", 32'(wb_valid), 32'd0);
    check("rst_wait_data", 32'(wb_data), 32'd0);
    check("rst_wait_ready", 32'(req_ready), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_sel   = 2'($urandom_range(0, 3));
      alu_data  = DW'($urandom);
      sw_data   = DW'($urandom);
      imm_data  = IW'($urandom);
      mem_data  = DW'($urandom);
      mem_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) sw_enter = ~sw_enter;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
